logit_pwl: RTL and testbench

- Inverse of the team's piecewise-linear sigmoid. Accepts a probability y (Q1.15 unsigned) and returns x = logit(y) as signed Q2.5, the sigmoid's input format.
- Uses the inverse of the team's 3-segment PLAN approximation, so sigmoid(logit_pwl(y)) matches y within 1 LSB of x on unsaturated points.
- 3-stage pipeline with valid/ready flow control on both sides. Sits downstream of sigmoid in calibration and self-test datapaths.

---
 rtl/logit_pkg.sv | 39 +++
 rtl/logit_seg_eval.sv | 28 ++
 rtl/logit_pwl.sv | 100 ++++++++++
 tb/tb_logit_pwl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logit_pkg.sv
// logit_pkg: shared constants, widths and stage payload types for logit_pwl.
// LOGIT_ROUND_EN adds two fractional guard bits to the segment magnitude.
package logit_pkg;

  localparam logic [15:0] HALF_Y = 16'h4000;

  localparam int D_W = 15;

`ifdef LOGIT_ROUND_EN
  localparam int GUARD_W = 2;
`else
  localparam int GUARD_W = 0;
`endif

  localparam int M_W = 10 + GUARD_W;

  localparam logic [D_W-1:0] SEG1_D = 15'd8192;
  localparam logic [D_W-1:0] SEG2_D = 15'd13824;

  localparam int OFF1 = 32;
  localparam int OFF2 = 352;

  localparam int TR_FF   = 24;
  localparam int TR_FA   = 28;
  localparam int TR_MUX2 = 12;

  typedef struct packed {
    logic           s;
    logic           sat;
    logic [D_W-1:0] d;
  } s1_t;

  typedef struct packed {
    logic           s;
    logic           sat;
    logic [M_W-1:0] m;
  } s2_t;

endpackage

// File: rtl/logit_seg_eval.sv
// logit_seg_eval: picks the PLAN segment from the folded distance d and
// turns it into the Q2.5 magnitude (with guard bits when LOGIT_ROUND_EN).
module logit_seg_eval
  import logit_pkg::*;
(
  input  logic [D_W-1:0] d,
  output logic [M_W-1:0] m,
  output logic [50:0]    number
);

  localparam logic [M_W-1:0] OFF1_M = M_W'(OFF1 << GUARD_W);
  localparam logic [M_W-1:0] OFF2_M = M_W'(OFF2 << GUARD_W);

  assign number = 51'((2 * D_W + 2 * M_W) * TR_FA + 2 * M_W * TR_MUX2);

  // Each segment is an inverse slope (shift) followed by an offset removal.
  always_comb begin
    m = '0;
    if (d < SEG1_D) begin
      m = M_W'(d >> (8 - GUARD_W));
    end else if (d < SEG2_D) begin
      m = M_W'(d >> (7 - GUARD_W)) - OFF1_M;
    end else begin
      m = M_W'(d >> (5 - GUARD_W)) - OFF2_M;
    end
  end

endmodule

// File: rtl/logit_pwl.sv
// logit_pwl: 3-stage pipelined inverse of the 3-segment PLAN sigmoid.
// Q1.15 unsigned probability in, signed Q2.5 logit out, valid/ready both sides.
// Build option LOGIT_ROUND_EN: round the magnitude half-up instead of truncating.
// Note: rst_n is a synchronous, active-high reset despite its name.
module logit_pwl
  import logit_pkg::*;
#(
  parameter int X_MAX = 127,
  parameter int X_MIN = -128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [15:0] i_y,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [7:0]  o_x,
  output logic [50:0] number
);

  localparam logic [10:0] POS_LIM = 11'(X_MAX);
  localparam logic [10:0] NEG_LIM = 11'(-X_MIN);
  localparam logic [7:0]  X_MAX_B = 8'(X_MAX);
  localparam int          FF_BITS = 3 + $bits(s1_t) + $bits(s2_t) + 8;

  logic        en;
  logic        v1, v2, v3;
  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;
  logic [M_W-1:0] m_d;
  logic [50:0] seg_number;
  logic [10:0] mag;
  logic [7:0]  mag_lim;
  logic [7:0]  x_d;

  assign en          = !v3 || i_out_ready;
  assign o_in_ready  = en;
  assign o_out_valid = v3;
  assign number      = seg_number + 51'(FF_BITS * TR_FF + (D_W + 16) * TR_FA);

  // S1: fold around y = 0.5; sign of x and distance from the midpoint.
  always_comb begin
    s1_d     = '0;
    s1_d.s   = (i_y >= HALF_Y);
    s1_d.sat = i_y[15];
    s1_d.d   = s1_d.s ? D_W'(i_y - HALF_Y) : D_W'(HALF_Y - i_y);
  end

  logit_seg_eval u_seg (
    .d      (s1_q.d),
    .m      (m_d),
    .number (seg_number)
  );

  // S2 payload: carry sign and saturation alongside the segment magnitude.
  always_comb begin
    s2_d     = '0;
    s2_d.s   = s1_q.s;
    s2_d.sat = s1_q.sat;
    s2_d.m   = m_d;
  end

  // S3: drop guard bits, clamp the magnitude, then apply the sign.
  always_comb begin
`ifdef LOGIT_ROUND_EN
    mag = 11'(({1'b0, s2_q.m} + 13'd2) >> GUARD_W);
`else
    mag = 11'(s2_q.m);
`endif
    mag_lim = (mag > NEG_LIM) ? 8'(NEG_LIM) : mag[7:0];
    if (s2_q.sat) begin
      x_d = X_MAX_B;
    end else if (s2_q.s) begin
      x_d = (mag > POS_LIM) ? X_MAX_B : mag[7:0];
    end else begin
      x_d = 8'h00 - mag_lim;
    end
  end

  // Pipeline registers: all stages move together on en, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      o_x  <= 8'h00;
    end else if (en) begin
      v1 <= i_in_valid;
      v2 <= v1;
      v3 <= v2;
      if (i_in_valid) s1_q <= s1_d;
      if (v1)         s2_q <= s2_d;
      if (v2)         o_x  <= x_d;
    end
  end

endmodule

// File: tb/tb_logit_pwl.sv
// tb_logit_pwl: directed bench for logit_pwl with a forward PLAN sigmoid model
// for the sweep. Works with or without LOGIT_ROUND_EN.
module tb_logit_pwl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [15:0] i_y;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [7:0]  o_x;
  logic [50:0] number;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [7:0] out_x[$];
  int         out_cyc[$];
  int         in_cyc[$];

  logit_pwl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_y         (i_y),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_x         (o_x),
    .number      (number)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp handshakes.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every handshake on both sides, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (i_in_valid && o_in_ready) in_cyc.push_back(cyc);
      if (o_out_valid && i_out_ready) begin
        out_x.push_back(o_x);
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic [15:0] y);
    i_in_valid = valid;
    i_y        = y;
    tick();
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bound(input string tag, input int obs, input int lim, input int y);
    tests_run++;
    assert (obs <= lim) else begin
      tests_failed++;
      $error("FAIL %s: y=%0h error %0d exceeds bound %0d", tag, y, obs, lim);
    end
  endtask

  task automatic clear_queues();
    out_x.delete();
    out_cyc.delete();
    in_cyc.delete();
  endtask

  task automatic wait_out(input int n, input int budget);
    int k = 0;
    while (out_x.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_output("out_count", out_x.size(), n);
  endtask

  function automatic logic [7:0] out_at(input int j);
    if (j < out_x.size()) return out_x[j];
    return 8'hxx;
  endfunction

  function automatic int ocyc_at(input int j);
    if (j < out_cyc.size()) return out_cyc[j];
    return -1000;
  endfunction

  function automatic int icyc_at(input int j);
    if (j < in_cyc.size()) return in_cyc[j];
    return 1000;
  endfunction

  // Forward PLAN sigmoid: distance from 0x4000 for magnitude m (Q2.5 raw).
  function automatic int sig_d(input int m);
    if (m < 32) return 256 * m;
    if (m < 76) return 128 * m + 4096;
    return 32 * m + 11264;
  endfunction

  // One x LSB expressed in y units, by segment of the input distance.
  function automatic int tol_for(input int d);
    if (d < 8192) return 256;
    if (d < 13824) return 128;
    return 32;
  endfunction

  initial begin
    int y, d, xi, mag, yh, err;
    logic [7:0] a, b, nb;
    logic sat_ok;

    rst_n       = 1'b1;
    i_in_valid  = 1'b1;
    i_y         = 16'h4000;
    i_out_ready = 1'b1;

    // Reset held with valid input: nothing comes out, o_x cleared.
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output("rst_valid", o_out_valid, 1'b0);
      check_output("rst_x", o_x, 8'h00);
    end
    check_output("number_known", $isunknown(number), 1'b0);
    clear_queues();
    rst_n = 1'b0;
    check_output("ready_after_rst", o_in_ready, 1'b1);
    apply_stimulus(1'b1, 16'h4000);
    i_in_valid = 1'b0;
    wait_out(1, 10);
    check_output("mid_x", out_at(0), 8'h00);
    check_output("mid_lat", ocyc_at(0) - icyc_at(0), 3);

    // Back-to-back, one per segment.
    clear_queues();
    apply_stimulus(1'b1, 16'h6000);
    apply_stimulus(1'b1, 16'h2000);
    apply_stimulus(1'b1, 16'h7800);
    i_in_valid = 1'b0;
    wait_out(3, 20);
    check_output("bb0", out_at(0), 8'h20);
    check_output("bb1", out_at(1), 8'hE0);
    check_output("bb2", out_at(2), 8'h60);
    check_output("bb_lat", ocyc_at(0) - icyc_at(0), 3);
    check_output("bb_gap1", ocyc_at(1) - ocyc_at(0), 1);
    check_output("bb_gap2", ocyc_at(2) - ocyc_at(0), 2);

    // Saturation points.
    clear_queues();
    apply_stimulus(1'b1, 16'h7FFF);
    apply_stimulus(1'b1, 16'h0000);
    apply_stimulus(1'b1, 16'h8000);
    i_in_valid = 1'b0;
    wait_out(3, 20);
    check_output("sat_7fff", out_at(0), 8'h7F);
    check_output("sat_0000", out_at(1), 8'h80);
    check_output("sat_8000", out_at(2), 8'h7F);

    // Back-pressure: fill the pipe, stall 4 cycles, then drain.
    clear_queues();
    i_out_ready = 1'b0;
    apply_stimulus(1'b1, 16'h6000);
    apply_stimulus(1'b1, 16'h4000);
    apply_stimulus(1'b1, 16'h2000);
    i_y = 16'h7800;
    for (int k = 0; k < 4; k++) begin
      check_output("stall_ready", o_in_ready, 1'b0);
      check_output("stall_valid", o_out_valid, 1'b1);
      check_output("stall_x", o_x, 8'h20);
      tick();
    end
    i_out_ready = 1'b1;
    apply_stimulus(1'b1, 16'h7800);
    apply_stimulus(1'b1, 16'h7FFF);
    i_in_valid = 1'b0;
    wait_out(5, 30);
    check_output("stall_o0", out_at(0), 8'h20);
    check_output("stall_o1", out_at(1), 8'h00);
    check_output("stall_o2", out_at(2), 8'hE0);
    check_output("stall_o3", out_at(3), 8'h60);
    check_output("stall_o4", out_at(4), 8'h7F);
    repeat (5) tick();
    check_output("stall_no_dup", out_x.size(), 5);
    check_output("stall_in_count", in_cyc.size(), 5);

    // Reset with three items in flight: none may emerge.
    clear_queues();
    i_out_ready = 1'b0;
    apply_stimulus(1'b1, 16'h6000);
    apply_stimulus(1'b1, 16'h2000);
    apply_stimulus(1'b1, 16'h7800);
    i_in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check_output("flush_valid", o_out_valid, 1'b0);
    check_output("flush_x", o_x, 8'h00);
    rst_n = 1'b0;
    i_out_ready = 1'b1;
    repeat (8) tick();
    check_output("flush_none", out_x.size(), 0);

    // Sweep y in steps of 0x0100 and check against the forward model.
    clear_queues();
    for (int j = 0; j <= 128; j++) apply_stimulus(1'b1, 16'(j * 256));
    i_in_valid = 1'b0;
    wait_out(129, 50);
    check_output("sweep_top", out_at(128), 8'h7F);
    for (int j = 0; j < 128; j++) begin
      y  = j * 256;
      d  = (y >= 16384) ? y - 16384 : 16384 - y;
      xi = int'($signed(out_at(j)));
      if (xi == 127 || xi == -128) begin
        sat_ok = (xi == 127) ? (y >= 16384 && d >= 15296) : (y < 16384 && d >= 15328);
        check_output("sweep_sat", sat_ok, 1'b1);
      end else begin
        mag = (xi < 0) ? -xi : xi;
        yh  = (xi >= 0) ? 16384 + sig_d(mag) : 16384 - sig_d(mag);
        err = (yh > y) ? yh - y : y - yh;
        check_bound("sweep_err", err, tol_for(d), y);
      end
    end
    for (int j = 1; j < 64; j++) begin
      a = out_at(j);
      b = out_at(128 - j);
      if (a != 8'h7F && a != 8'h80 && b != 8'h7F && b != 8'h80) begin
        nb = 8'h00 - b;
        check_output("sym", a, nb);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
